// File: rtl/selector_pixel_scheduler.sv
// Pixel scheduler: raster-scans a frame through the block selector and
// emits one classified result per pixel over a valid/ready handshake.
//
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   start_in, abort_in        start a frame scan / abandon the scan
//   sel_x_out, sel_y_out      coordinate presented to the selector
//   sel_valid_in, sel_x_in,
//   sel_y_in, sel_*_visible_in,
//   sel_block_ID_in           selector result with echoed coordinate
//   pix_valid_out/ready_in    pixel result handshake
//   pix_x_out, pix_y_out,
//   pix_hit_out, pix_ID_out   pixel result (hit: 0 none 1 block 2 saber 3 timeout)
//   busy_out                  scan in progress
//   frame_done_out            one-cycle pulse after the last pixel transfers
//   timeout_count_out         saturating count of timed-out pixels
module selector_pixel_scheduler #(
    parameter int H_PIXELS = 1024,
    parameter int V_PIXELS = 768,
    parameter int SETTLE   = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        abort_in,
    output logic [10:0] sel_x_out,
    output logic [9:0]  sel_y_out,
    input  logic        sel_valid_in,
    input  logic [10:0] sel_x_in,
    input  logic [9:0]  sel_y_in,
    input  logic        sel_block_visible_in,
    input  logic        sel_saber_visible_in,
    input  logic [7:0]  sel_block_ID_in,
    output logic        pix_valid_out,
    input  logic        pix_ready_in,
    output logic [10:0] pix_x_out,
    output logic [9:0]  pix_y_out,
    output logic [1:0]  pix_hit_out,
    output logic [7:0]  pix_ID_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [7:0]  timeout_count_out
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [10:0]   X_LAST    = 11'(H_PIXELS - 1);
    localparam logic [9:0]    Y_LAST    = 10'(V_PIXELS - 1);
    localparam logic [SW-1:0] SETTLE_L  = SW'(SETTLE);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t        r_state;
    logic [10:0]   r_x;
    logic [9:0]    r_y;
    logic [SW-1:0] r_settle;
    logic [WW-1:0] r_wait;
    logic [10:0]   r_sel_x;
    logic [9:0]    r_sel_y;
    logic          r_pix_valid;
    logic [10:0]   r_pix_x;
    logic [9:0]    r_pix_y;
    logic [1:0]    r_pix_hit;
    logic [7:0]    r_pix_id;
    logic          r_frame_done;
    logic [7:0]    r_tcount;

    logic       w_match;
    logic       w_timeout;
    logic       w_last;
    logic [1:0] w_hit;
    logic [7:0] w_id;

    // A result counts only once the coordinate has settled and the
    // selector echoes the coordinate we are currently presenting.
    assign w_match = (r_settle == '0) && sel_valid_in &&
                     (sel_x_in == r_sel_x) && (sel_y_in == r_sel_y);

    // Last WAIT cycle: leaving now makes exactly TIMEOUT cycles in WAIT.
    assign w_timeout = (r_wait == WAIT_LAST);

    assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

    // Saber wins over block; the ID is meaningful for block hits only.
    always_comb begin
        w_hit = 2'd0;
        w_id  = 8'd0;
        if (sel_saber_visible_in) begin
            w_hit = 2'd2;
        end else if (sel_block_visible_in) begin
            w_hit = 2'd1;
            w_id  = sel_block_ID_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_settle     <= '0;
            r_wait       <= '0;
            r_sel_x      <= '0;
            r_sel_y      <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_hit    <= '0;
            r_pix_id     <= '0;
            r_frame_done <= 1'b0;
            r_tcount     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (abort_in) begin
                // Also covers start+abort in IDLE: stay idle.
                r_state     <= S_IDLE;
                r_pix_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start_in) begin
                            r_x     <= '0;
                            r_y     <= '0;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_sel_x  <= r_x;
                        r_sel_y  <= r_y;
                        r_settle <= SETTLE_L;
                        r_wait   <= '0;
                        r_state  <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_wait <= r_wait + 1'b1;
                        if (r_settle != '0) begin
                            r_settle <= r_settle - 1'b1;
                        end
                        if (w_match) begin
                            r_pix_valid <= 1'b1;
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_hit   <= w_hit;
                            r_pix_id    <= w_id;
                            r_state     <= S_EMIT;
                        end else if (w_timeout) begin
                            r_pix_valid <= 1'b1;
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_hit   <= 2'd3;
                            r_pix_id    <= 8'd0;
                            r_state     <= S_EMIT;
                            if (r_tcount != 8'hFF) begin
                                r_tcount <= r_tcount + 1'b1;
                            end
                        end
                    end
                    S_EMIT: begin
                        if (pix_ready_in) begin
                            r_pix_valid <= 1'b0;
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                            if (w_last) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_IDLE;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sel_x_out         = r_sel_x;
    assign sel_y_out         = r_sel_y;
    assign pix_valid_out     = r_pix_valid;
    assign pix_x_out         = r_pix_x;
    assign pix_y_out         = r_pix_y;
    assign pix_hit_out       = r_pix_hit;
    assign pix_ID_out        = r_pix_id;
    assign busy_out          = (r_state != S_IDLE);
    assign frame_done_out    = r_frame_done;
    assign timeout_count_out = r_tcount;

endmodule

// File: tb/tb_selector_pixel_scheduler.sv
// Testbench for selector_pixel_scheduler: deadline-based pixel model,
// directed scenarios and a randomized phase.
module tb_selector_pixel_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int ST = 3;
    localparam int TO = 20;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic        abort_in;
    logic [10:0] sel_x_out;
    logic [9:0]  sel_y_out;
    logic        sel_valid_in;
    logic [10:0] sel_x_in;
    logic [9:0]  sel_y_in;
    logic        sel_block_visible_in;
    logic        sel_saber_visible_in;
    logic [7:0]  sel_block_ID_in;
    logic        pix_valid_out;
    logic        pix_ready_in;
    logic [10:0] pix_x_out;
    logic [9:0]  pix_y_out;
    logic [1:0]  pix_hit_out;
    logic [7:0]  pix_ID_out;
    logic        busy_out;
    logic        frame_done_out;
    logic [7:0]  timeout_count_out;

    selector_pixel_scheduler #(
        .H_PIXELS(H),
        .V_PIXELS(V),
        .SETTLE  (ST),
        .TIMEOUT (TO)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .start_in            (start_in),
        .abort_in            (abort_in),
        .sel_x_out           (sel_x_out),
        .sel_y_out           (sel_y_out),
        .sel_valid_in        (sel_valid_in),
        .sel_x_in            (sel_x_in),
        .sel_y_in            (sel_y_in),
        .sel_block_visible_in(sel_block_visible_in),
        .sel_saber_visible_in(sel_saber_visible_in),
        .sel_block_ID_in     (sel_block_ID_in),
        .pix_valid_out       (pix_valid_out),
        .pix_ready_in        (pix_ready_in),
        .pix_x_out           (pix_x_out),
        .pix_y_out           (pix_y_out),
        .pix_hit_out         (pix_hit_out),
        .pix_ID_out          (pix_ID_out),
        .busy_out            (busy_out),
        .frame_done_out      (frame_done_out),
        .timeout_count_out   (timeout_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;
    int cur   = 0;

    // Model: a scan is a pixel index plus the cycle its wait window opens.
    bit          m_busy;
    bit          m_emit;
    bit          m_rst;
    int          m_n;
    int          m_w0;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic [10:0] e_x;
    logic [9:0]  e_y;
    logic [1:0]  e_hit;
    logic [7:0]  e_id;
    logic [10:0] e_selx;
    logic [9:0]  e_sely;
    int          e_tc;

    int sel_mode;
    bit rnd_ready;
    int hold_left;
    int stale_left;
    int fd_count = 0;

    int tq_x[$];
    int tq_y[$];
    int tq_hit[$];
    int tq_id[$];
    int tq_t[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cur);
        end
    endtask

    task automatic model_step();
        int j;
        e_done = 1'b0;
        m_rst  = 1'b0;
        if (!rst_n_in) begin
            m_rst  = 1'b1;
            m_busy = 1'b0;
            m_emit = 1'b0;
            e_x    = '0;
            e_y    = '0;
            e_hit  = '0;
            e_id   = '0;
            e_tc   = 0;
            e_selx = '0;
            e_sely = '0;
        end else if (!m_busy) begin
            if (start_in && !abort_in) begin
                m_busy = 1'b1;
                m_n    = 0;
                m_w0   = cur + 2;
            end
        end else if (abort_in) begin
            m_busy = 1'b0;
            m_emit = 1'b0;
        end else if (m_emit) begin
            if (pix_ready_in) begin
                m_emit = 1'b0;
                if (m_n == H * V - 1) begin
                    m_busy = 1'b0;
                    e_done = 1'b1;
                end else begin
                    m_n++;
                    m_w0 = cur + 2;
                end
            end
        end else if (cur < m_w0) begin
            // The selector sees the new coordinate when waiting begins.
            e_selx = 11'(m_n % H);
            e_sely = 10'(m_n / H);
        end else begin
            j = cur - m_w0;
            if (j >= ST && sel_valid_in &&
                int'(sel_x_in) == m_n % H && int'(sel_y_in) == m_n / H) begin
                m_emit = 1'b1;
                e_x    = 11'(m_n % H);
                e_y    = 10'(m_n / H);
                e_hit  = sel_saber_visible_in ? 2'd2 :
                         (sel_block_visible_in ? 2'd1 : 2'd0);
                e_id   = (e_hit == 2'd1) ? sel_block_ID_in : 8'd0;
            end else if (j == TO - 1) begin
                m_emit = 1'b1;
                e_x    = 11'(m_n % H);
                e_y    = 10'(m_n / H);
                e_hit  = 2'd3;
                e_id   = 8'd0;
                if (e_tc < 255) e_tc++;
            end
        end
        e_valid = m_emit;
        e_busy  = m_busy;
        cur++;
    endtask

    task automatic check_outputs();
        chk("pix_valid", pix_valid_out, e_valid);
        chk("busy", busy_out, e_busy);
        chk("frame_done", frame_done_out, e_done);
        chk("timeout_count", timeout_count_out, e_tc);
        chk("sel_x", sel_x_out, e_selx);
        chk("sel_y", sel_y_out, e_sely);
        if (e_valid || m_rst) begin
            chk("pix_x", pix_x_out, e_x);
            chk("pix_y", pix_y_out, e_y);
            chk("pix_hit", pix_hit_out, e_hit);
            chk("pix_ID", pix_ID_out, e_id);
        end
        if (frame_done_out) fd_count++;
    endtask

    task automatic step();
        if (rst_n_in && !abort_in && pix_valid_out && pix_ready_in) begin
            tq_x.push_back(int'(pix_x_out));
            tq_y.push_back(int'(pix_y_out));
            tq_hit.push_back(int'(pix_hit_out));
            tq_id.push_back(int'(pix_ID_out));
            tq_t.push_back(cur);
        end
        model_step();
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic drive();
        sel_valid_in         = 1'b1;
        sel_x_in             = sel_x_out;
        sel_y_in             = sel_y_out;
        sel_block_visible_in = 1'b1;
        sel_saber_visible_in = 1'b0;
        sel_block_ID_in      = 8'h2A;
        case (sel_mode)
            0: sel_valid_in = 1'b0;
            2: begin
                sel_saber_visible_in = 1'b1;
                sel_block_ID_in      = 8'h55;
            end
            3: begin
                if (sel_x_out == 11'd1 && sel_y_out == 10'd0 &&
                    stale_left > 0) begin
                    sel_x_in = '0;
                    sel_y_in = '0;
                    stale_left--;
                end
            end
            4: begin
                sel_valid_in = 1'($urandom % 2);
                if ($urandom % 4 == 0) begin
                    sel_x_in = 11'($urandom % H);
                    sel_y_in = 10'($urandom % V);
                end
                sel_block_visible_in = 1'($urandom % 2);
                sel_saber_visible_in = ($urandom % 4 == 0);
                sel_block_ID_in      = 8'($urandom);
            end
            default: ;
        endcase
        if (hold_left > 0 && pix_valid_out) begin
            pix_ready_in = 1'b0;
            hold_left--;
        end else begin
            pix_ready_in = rnd_ready ? ($urandom % 3 != 0) : 1'b1;
        end
    endtask

    task automatic tick();
        drive();
        step();
    endtask

    task automatic go(output int s);
        s        = cur;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        int k = 0;
        while (m_busy && k < bound) begin
            tick();
            k++;
        end
        if (m_busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL idle_bound: scan still running after %0d cycles", bound);
        end
    endtask

    task automatic wait_valid(input int bound);
        int k = 0;
        while (!pix_valid_out && k < bound) begin
            tick();
            k++;
        end
        if (!pix_valid_out) begin
            n_vec++;
            n_bad++;
            $display("FAIL valid_bound: no pixel result within %0d cycles", bound);
        end
    endtask

    task automatic clear_q();
        tq_x.delete();
        tq_y.delete();
        tq_hit.delete();
        tq_id.delete();
        tq_t.delete();
    endtask

    // Hand expectation: one frame in raster order with a fixed result.
    task automatic verify_frame(input int hit, input int id);
        chk("xfer_count", tq_x.size(), H * V);
        for (int i = 0; i < tq_x.size() && i < H * V; i++) begin
            chk("xfer_x", tq_x[i], i % H);
            chk("xfer_y", tq_y[i], i / H);
            chk("xfer_hit", tq_hit[i], hit);
            chk("xfer_id", tq_id[i], id);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int fd0;
        rst_n_in             = 1'b0;
        start_in             = 1'b0;
        abort_in             = 1'b0;
        sel_valid_in         = 1'b0;
        sel_x_in             = '0;
        sel_y_in             = '0;
        sel_block_visible_in = 1'b0;
        sel_saber_visible_in = 1'b0;
        sel_block_ID_in      = '0;
        pix_ready_in         = 1'b0;
        sel_mode             = 1;
        rnd_ready            = 1'b0;
        hold_left            = 0;
        stale_left           = 0;

        @(negedge clk_in);
        repeat (3) step();
        rst_n_in = 1'b1;
        repeat (2) tick();

        // Echoing selector, ready always high.
        clear_q();
        fd0 = fd_count;
        go(s);
        wait_valid(50);
        // start cycle, ISSUE, 3 settle cycles, accept cycle, then EMIT
        chk("first_latency", cur - s, 6);
        run_idle(400);
        verify_frame(1, 8'h2A);
        chk("frame_done_once", fd_count - fd0, 1);
        chk("idle_sel_x", sel_x_out, 3);
        chk("idle_sel_y", sel_y_out, 1);

        // Saber and block both visible.
        sel_mode = 2;
        clear_q();
        go(s);
        run_idle(400);
        verify_frame(2, 0);

        // Stale (0,0) echo held for 8 cycles while (1,0) is presented.
        sel_mode   = 3;
        stale_left = 8;
        clear_q();
        go(s);
        run_idle(400);
        verify_frame(1, 8'h2A);
        if (tq_t.size() >= 2) chk("stale_gap", tq_t[1] - tq_t[0], 11);

        // Ready held low for 10 cycles on the first result.
        sel_mode  = 1;
        hold_left = 10;
        clear_q();
        go(s);
        run_idle(400);
        verify_frame(1, 8'h2A);
        if (tq_t.size() >= 1) chk("hold_xfer_time", tq_t[0] - s, 16);

        // Abort while a result is waiting, with ready high.
        clear_q();
        fd0 = fd_count;
        go(s);
        wait_valid(50);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_valid", pix_valid_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_done", frame_done_out, 0);
        repeat (20) tick();
        chk("abort_no_xfer", tq_x.size(), 0);
        chk("abort_no_done", fd_count - fd0, 0);

        // Reset while waiting on the selector.
        go(s);
        repeat (2) tick();
        rst_n_in = 1'b0;
        #1;
        chk("rst_async_valid", pix_valid_out, 0);
        chk("rst_async_busy", busy_out, 0);
        chk("rst_async_sel_x", sel_x_out, 0);
        step();
        step();
        rst_n_in = 1'b1;
        fd0 = fd_count;
        repeat (30) tick();
        chk("post_reset_no_xfer", tq_x.size(), 0);
        chk("post_reset_no_done", fd_count - fd0, 0);
        go(s);
        run_idle(400);
        verify_frame(1, 8'h2A);

        // Silent selector: every pixel times out.
        sel_mode = 0;
        clear_q();
        go(s);
        run_idle(400);
        verify_frame(3, 0);
        if (tq_t.size() >= 2) begin
            chk("timeout_first", tq_t[0] - s, 2 + TO);
            chk("timeout_gap", tq_t[1] - tq_t[0], 2 + TO);
        end
        chk("timeout_count_8", timeout_count_out, 8);
        repeat (37) begin
            go(s);
            run_idle(400);
        end
        chk("timeout_saturated", timeout_count_out, 255);

        // Random selector, ready, start and abort.
        sel_mode  = 4;
        rnd_ready = 1'b1;
        repeat (3000) begin
            start_in = ($urandom % 6 == 0);
            abort_in = ($urandom % 150 == 0);
            tick();
        end
        start_in = 1'b0;
        abort_in = 1'b0;
        run_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/selector_pixel_scheduler.md
SELECTOR_PIXEL_SCHEDULER -- requirements
Module: selector_pixel_scheduler

Interface
REQ-001 Parameters SHALL be: H_PIXELS, default 1024, pixels per row; V_PIXELS, default 768, rows per frame; SETTLE, default 3, cycles to ignore results after a new coordinate is driven; TIMEOUT, default 64, maximum wait cycles per pixel.
REQ-002 Ports SHALL be as follows, one per line:
clk_in  input  1  system clock; all state changes on its rising edge
rst_n_in  input  1  reset; asynchronous assert, active-low
start_in  input  1  one-cycle pulse that starts a frame scan; ignored unless the block is IDLE
abort_in  input  1  aborts the scan in progress
sel_x_out  output  11  pixel X coordinate driven to the block selector
sel_y_out  output  10  pixel Y coordinate driven to the block selector
sel_valid_in  input  1  result-valid flag from the selector
sel_x_in  input  11  X coordinate echoed back with the selector result
sel_y_in  input  10  Y coordinate echoed back with the selector result
sel_block_visible_in  input  1  selector result: a block is hit
sel_saber_visible_in  input  1  selector result: the saber is hit
sel_block_ID_in  input  8  selector result: ID of the hit block
pix_valid_out  output  1  pixel result valid
pix_ready_in  input  1  downstream ready to accept a pixel result
pix_x_out  output  11  X coordinate of the pixel result
pix_y_out  output  10  Y coordinate of the pixel result
pix_hit_out  output  2  pixel hit code: 0 none, 1 block, 2 saber, 3 timeout
pix_ID_out  output  8  block ID of the pixel result
busy_out  output  1  high whenever the state is not IDLE
frame_done_out  output  1  one-cycle pulse when a frame completes
timeout_count_out  output  8  saturating count of timed-out pixels

Function
REQ-003 The block SHALL implement exactly four states: IDLE, ISSUE, WAIT, EMIT.
REQ-004 IDLE: when start_in=1, the block SHALL clear the pixel counters to x=0, y=0 and go to ISSUE.
REQ-005 ISSUE: the block SHALL drive sel_x_out/sel_y_out from the counters, load the settle counter with SETTLE and the wait counter with 0, then go to WAIT; this state lasts one cycle.
REQ-006 WAIT: while the settle counter is nonzero, the block SHALL ignore sel_valid_in and decrement the settle counter by 1 per cycle; the wait counter SHALL increment every cycle spent in WAIT.
REQ-007 WAIT: the block SHALL accept a result only on a cycle where the settle counter is 0, sel_valid_in=1, sel_x_in=sel_x_out and sel_y_in=sel_y_out; a result with mismatched coordinates SHALL be treated as stale and ignored.
REQ-008 On accepting a result, the block SHALL register pix_hit_out: 2 if sel_saber_visible_in=1 (saber takes priority), else 1 if sel_block_visible_in=1, else 0.
REQ-009 On accepting a result, the block SHALL register pix_ID_out from sel_block_ID_in when pix_hit_out=1, otherwise 0; it SHALL register pix_x_out/pix_y_out from the counters and go to EMIT.
REQ-010 WAIT: if the wait counter reaches TIMEOUT with no result accepted, the block SHALL emit pix_hit_out=3 with pix_ID_out=0 and increment timeout_count_out, saturating at 255.
REQ-011 EMIT: pix_valid_out SHALL be 1 and pix_x_out, pix_y_out, pix_hit_out, pix_ID_out SHALL be held stable until the cycle in which pix_ready_in=1; a transfer occurs on that cycle.
REQ-012 After a transfer, the block SHALL increment x; when x=H_PIXELS-1 it SHALL wrap x to 0 and increment y.
REQ-013 When the transferred pixel is (H_PIXELS-1, V_PIXELS-1), the block SHALL pulse frame_done_out for one cycle and go to IDLE; otherwise it SHALL go to ISSUE.
REQ-014 The latency from start_in to the first pix_valid_out SHALL be at least SETTLE+2 cycles.
REQ-015 abort_in=1 in any non-IDLE state SHALL force IDLE on the next edge and drop pix_valid_out with no transfer; frame_done_out SHALL NOT pulse; abort_in takes priority over a simultaneous transfer.
REQ-016 start_in while busy_out=1 SHALL be ignored; start_in and abort_in asserted together in IDLE SHALL be treated as abort (remain IDLE).
REQ-017 sel_x_out/sel_y_out SHALL hold the current pixel coordinate through WAIT and EMIT, and SHALL hold the last pixel coordinate in IDLE.

Reset
REQ-018 While rst_n_in=0, the block SHALL be in IDLE with every output at 0: sel_x_out, sel_y_out, pix_valid_out, pix_x_out, pix_y_out, pix_hit_out, pix_ID_out, busy_out, frame_done_out, timeout_count_out.
REQ-019 Reset asserted mid-frame SHALL discard the scan, and no pixel result SHALL appear after rst_n_in is released until a new start_in.

Verification
REQ-020 With H_PIXELS=4, V_PIXELS=2, a selector model returning block ID 0x2A, ready held at 1 and a start pulse: the bench SHALL see 8 transfers in raster order (0,0)..(3,1), all with hit=1 and ID=0x2A, and frame_done pulsing once.
REQ-021 With a model that holds a stale valid at (0,0) while the new coordinate is (1,0): the bench SHALL see no transfer for (1,0) until the echoed coordinate is (1,0).
REQ-022 With saber and block both visible: the bench SHALL see hit=2 and ID=0.
REQ-023 With the selector silent: every pixel SHALL emit hit=3 exactly TIMEOUT cycles into WAIT, and timeout_count_out SHALL saturate at 255 after 300 such pixels.
REQ-024 With pix_ready_in held at 0 for 10 cycles during EMIT: the bench SHALL see outputs held stable for those cycles and exactly one transfer when ready is raised.
REQ-025 With abort_in during EMIT, and separately rst_n_in=0 during WAIT: the bench SHALL see pix_valid_out=0 on the next cycle, IDLE, and no frame_done pulse.
